// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
//   Result buffer placed directly behind the two-operand ALU stage. Each
//   entry holds the 8-bit ALU result S together with the 2-bit mode M that
//   produced it. The ALU stage cannot be stalled. Every valid input is
//   therefore pushed if there is room. If there is no room, the input is
//   dropped and recorded in a sticky OVERRUN flag and a saturating DROPS
//   counter.
//   Readout is first-word-fall-through. OUT_DATA/OUT_M show the head entry
//   while OUT_VALID is high. OUT_READY accepts the head entry.
//
// Ports
//   CLK        clock, rising edge
//   RST        asynchronous reset, active-high
//   S_IN       ALU result to store
//   M_IN       ALU mode tag (00 add, 01 sub, 10 or, 11 and)
//   IN_VALID   S_IN/M_IN valid this cycle (pushed unconditionally if room)
//   IN_READY   not full; informational only
//   OUT_DATA   head entry result, 0 when empty
//   OUT_M      head entry mode tag, 0 when empty
//   OUT_VALID  FIFO non-empty
//   OUT_READY  consumer accepts the head entry this cycle
//   CLR        synchronous flush: empties FIFO, clears OVERRUN and DROPS
//   COUNT      number of entries held, 0..DEPTH
//   OVERRUN    sticky flag: at least one valid input was dropped
//   DROPS      number of dropped inputs, saturates at 255
// ---------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         S_IN,
    input  logic [1:0]               M_IN,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    output logic [WIDTH-1:0]         OUT_DATA,
    output logic [1:0]               OUT_M,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    input  logic                     CLR,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERRUN,
    output logic [7:0]               DROPS
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WIDTH + 2;

    // Storage: {mode, result} per entry. The contents are don't-care after
    // reset, so the array is not reset.
    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    drops_q,  drops_d;

    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;
    logic          wr_en;
    logic [EW-1:0] head_word;

    // Status comes only from the registered count. This keeps
    // OUT_VALID/IN_READY free of any combinational path from the inputs.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A pop frees a slot in the same edge. A full FIFO that is also popping
    // therefore still accepts the input.
    assign pop   = ~empty & OUT_READY;
    assign push  = IN_VALID & (~full | pop);
    assign drop  = IN_VALID & full & ~pop;
    assign wr_en = push & ~CLR;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        drops_d   = drops_q;

        if (CLR) begin
            // A flush overrides any push or pop in the same cycle.
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            overrun_d = 1'b0;
            drops_d   = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                overrun_d = 1'b1;
                if (drops_q != 8'hFF) begin
                    drops_d = drops_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            drops_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            drops_q   <= drops_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {M_IN, S_IN};
        end
    end

    // The head entry is read combinationally from storage. It is masked to
    // zero while empty, so stale or uninitialised words never show.
    assign head_word = mem_q[rd_ptr_q];

    assign OUT_VALID = ~empty;
    assign IN_READY  = ~full;
    assign OUT_DATA  = empty ? '0 : head_word[WIDTH-1:0];
    assign OUT_M     = empty ? 2'b00 : head_word[EW-1:WIDTH];
    assign COUNT     = count_q;
    assign OVERRUN   = overrun_q;
    assign DROPS     = drops_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_alu_result_fifo
//   Scoreboard bench for alu_result_fifo (WIDTH=8, DEPTH=4). Each clocked
//   step first compares every DUT output with a small queue model. It then
//   applies the push/pop/drop/flush rules to that model and advances one
//   clock. Directed sequences cover the following cases:
//     - reset
//     - ordering
//     - overflow
//     - full with a simultaneous pop
//     - pointer wrap
//     - DROPS saturation
//     - CLR flush
//     - asynchronous reset in mid-stream
// ---------------------------------------------------------------------------
module tb_alu_result_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] S_IN;
    logic [1:0]       M_IN;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] OUT_DATA;
    logic [1:0]       OUT_M;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             CLR;
    logic [2:0]       COUNT;
    logic             OVERRUN;
    logic [7:0]       DROPS;

    int checks_reg   = 0;
    int failures_reg = 0;

    // Model state: queued {M, S} words, the sticky flag and the drop count.
    logic [9:0] exp_q [$];
    bit         m_overrun;
    int         m_drops;

    alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .S_IN      (S_IN),
        .M_IN      (M_IN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_M     (OUT_M),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .CLR       (CLR),
        .COUNT     (COUNT),
        .OVERRUN   (OVERRUN),
        .DROPS     (DROPS)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input int observed, input int expected);
        checks_reg++;
        if (observed != expected) begin
            failures_reg++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_overrun = 1'b0;
        m_drops   = 0;
    endtask

    // Compare all outputs with the model, apply this cycle's inputs to the
    // model, then advance to 1 ns after the next rising edge.
    task automatic cycle();
        bit pop_m;
        bit push_m;
        int sz;
        sz = exp_q.size();
        check_eq("out_valid", 32'(OUT_VALID), 32'(sz != 0));
        check_eq("in_ready",  32'(IN_READY),  32'(sz != DEPTH));
        check_eq("count",     32'(COUNT),     sz);
        check_eq("overrun",   32'(OVERRUN),   32'(m_overrun));
        check_eq("drops",     32'(DROPS),     m_drops);
        if (sz != 0) begin
            check_eq("out_data", 32'(OUT_DATA), 32'(exp_q[0][7:0]));
            check_eq("out_m",    32'(OUT_M),    32'(exp_q[0][9:8]));
        end else begin
            check_eq("out_data_empty", 32'(OUT_DATA), 0);
            check_eq("out_m_empty",    32'(OUT_M),    0);
        end
        if (CLR) begin
            $display("clr flush (discarding %0d entries)", sz);
            model_clear();
        end else begin
            pop_m  = (sz != 0) && OUT_READY;
            push_m = IN_VALID && ((sz < DEPTH) || pop_m);
            if (pop_m) begin
                $display("pop  data=%02h m=%0d", exp_q[0][7:0], exp_q[0][9:8]);
                void'(exp_q.pop_front());
            end
            if (push_m) begin
                $display("push data=%02h m=%0d", S_IN, M_IN);
                exp_q.push_back({M_IN, S_IN});
            end
            if (IN_VALID && !push_m) begin
                $display("drop data=%02h m=%0d", S_IN, M_IN);
                m_overrun = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input bit v, input logic [7:0] s, input logic [1:0] m, input bit rdy);
        IN_VALID  = v;
        S_IN      = s;
        M_IN      = m;
        OUT_READY = rdy;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_count"},    32'(COUNT),     0);
        check_eq({tag, "_out_valid"},32'(OUT_VALID), 0);
        check_eq({tag, "_out_data"}, 32'(OUT_DATA),  0);
        check_eq({tag, "_out_m"},    32'(OUT_M),     0);
        check_eq({tag, "_in_ready"}, 32'(IN_READY),  1);
        check_eq({tag, "_overrun"},  32'(OVERRUN),   0);
        check_eq({tag, "_drops"},    32'(DROPS),     0);
    endtask

    initial begin
        RST = 1'b1;
        CLR = 1'b0;
        drive(1'b0, 8'h00, 2'b00, 1'b0);
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        // 1: reset state
        check_reset_outputs("reset");
        RST = 1'b0;

        // 2: ordering, three pushes held then drained
        drive(1'b1, 8'h05, 2'b00, 1'b0); cycle();
        drive(1'b1, 8'hFB, 2'b01, 1'b0); cycle();
        drive(1'b1, 8'h0F, 2'b10, 1'b0); cycle();
        drive(1'b0, 8'h00, 2'b00, 1'b1);
        repeat (3) cycle();
        check_eq("order_empty_after_drain", 32'(OUT_VALID), 0);
        cycle();

        // 3: overflow, six pushes into a four-entry FIFO
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(8'h10 + i), 2'(i), 1'b0);
            cycle();
        end
        check_eq("ovf_count",    32'(COUNT),    4);
        check_eq("ovf_in_ready", 32'(IN_READY), 0);
        check_eq("ovf_overrun",  32'(OVERRUN),  1);
        check_eq("ovf_drops",    32'(DROPS),    2);

        // 4: full with a pop; AA is accepted without a drop
        drive(1'b1, 8'hAA, 2'b11, 1'b1);
        cycle();
        check_eq("fullpop_count", 32'(COUNT),    4);
        check_eq("fullpop_drops", 32'(DROPS),    2);
        check_eq("fullpop_head",  32'(OUT_DATA), 32'h11);
        drive(1'b0, 8'h00, 2'b00, 1'b1);
        repeat (5) cycle();

        // 5: wrap, push and pop together every cycle
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(i), 2'(i), 1'b1);
            cycle();
            check_eq("wrap_count_le1", 32'(COUNT <= 3'd1), 1);
        end
        drive(1'b0, 8'h00, 2'b00, 1'b1);
        repeat (2) cycle();

        // DROPS saturation: fill, then keep pushing with no consumer
        for (int i = 0; i < 264; i++) begin
            drive(1'b1, 8'(8'h40 + i), 2'b01, 1'b0);
            cycle();
        end
        check_eq("drops_saturated", 32'(DROPS), 255);

        // 6a: CLR clears state and discards a simultaneous push
        drive(1'b0, 8'h00, 2'b00, 1'b1);
        cycle();
        check_eq("pre_clr_count",   32'(COUNT),   3);
        check_eq("pre_clr_overrun", 32'(OVERRUN), 1);
        drive(1'b1, 8'h77, 2'b10, 1'b1);
        CLR = 1'b1;
        cycle();
        CLR = 1'b0;
        drive(1'b0, 8'h00, 2'b00, 1'b0);
        check_eq("clr_count",     32'(COUNT),     0);
        check_eq("clr_overrun",   32'(OVERRUN),   0);
        check_eq("clr_drops",     32'(DROPS),     0);
        check_eq("clr_out_valid", 32'(OUT_VALID), 0);
        cycle();

        // 6b: async reset between edges with three entries and an overrun
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'hC0 + i), 2'b11, 1'b0);
            cycle();
        end
        drive(1'b0, 8'h00, 2'b00, 1'b1);
        cycle();
        check_eq("pre_rst_count", 32'(COUNT), 3);
        drive(1'b0, 8'h00, 2'b00, 1'b0);
        RST = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_clear();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        cycle();

        // One short push/pop after reset confirms the pointers restarted.
        drive(1'b1, 8'h3C, 2'b01, 1'b0); cycle();
        drive(1'b0, 8'h00, 2'b00, 1'b1); cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks_reg, failures_reg);
        $finish;
    end

endmodule
